// File: rtl/pipe_result_collector.sv
// rtl/pipe_result_collector.sv - result capture FIFO and running statistics behind the arithmetic pipeline
// Issue-aligned valid delay line, FWFT result FIFO, saturating sum/count and sticky drop flag.
module pipe_result_collector #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [N-1:0]     f,
  input  logic             clear,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [7:0]       count,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]      FIFO_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]      FIFO_ONE  = (PW+1)'(1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};

  logic [LAT-1:0]   vld_q, vld_d;
  logic [N-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [PW:0]      cnt_q, cnt_d;
  logic [N-1:0]     data_q, data_d;
  logic [ACC_W-1:0] acc_q, acc_d, f_ext;
  logic [ACC_W:0]   sum;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             cap_v, pop, push;

  always_comb begin
    vld_d[0] = issue;
    for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];
  end

  assign cap_v   = vld_q[LAT-1];
  assign pop     = (cnt_q != '0) && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push    = cap_v && ((cnt_q != FIFO_FULL) || pop);
  assign rd_next = rd_ptr_q + 1'b1;
  assign f_ext   = {{(ACC_W-N){1'b0}}, f};
  assign sum     = {1'b0, acc_q} + {1'b0, f_ext};

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + FIFO_ONE;
    else if (!push && pop) cnt_d = cnt_q - FIFO_ONE;

    // Head register: last popped value is retained while empty.
    data_d = data_q;
    if (pop) begin
      if (cnt_q > FIFO_ONE) data_d = mem_q[rd_next];
      else if (push)        data_d = f;
    end else if (push && (cnt_q == '0)) begin
      data_d = f;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      acc_d   = push ? f_ext : '0;
      count_d = push ? 8'd1 : 8'd0;
      ovf_d   = 1'b0;
    end else if (push) begin
      acc_d   = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
      count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end else if (cap_v) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= f;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (cnt_q != '0);
  assign acc       = acc_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipe_result_collector.sv
// tb/tb_pipe_result_collector.sv - self-checking bench for pipe_result_collector
module tb_pipe_result_collector;

  localparam int N     = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int ACC_W = 10;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue = 1'b0;
  logic [N-1:0]     f = '0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic             overflow;

  int checks = 0;
  int failures = 0;

  int           m_due[$];
  logic [N-1:0] m_fifo[$];
  logic [N-1:0] m_last = '0;
  int           m_acc = 0;
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;
  int           cyc = 0;

  pipe_result_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .f(f), .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_data();
    return (m_fifo.size() > 0) ? m_fifo[0] : m_last;
  endfunction

  // Drive one edge and advance the reference model; outputs are then sampled 1 time unit after the edge.
  task automatic drive(input bit iss, input logic [N-1:0] fv, input bit rdy, input bit clr, input bit rstn);
    bit cap, pop, room;
    @(negedge clk);
    issue = iss; f = fv; out_ready = rdy; clear = clr; rst_n = rstn;
    @(posedge clk);
    if (!rstn) begin
      m_due.delete(); m_fifo.delete();
      m_last = '0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    end else begin
      cap = (m_due.size() > 0) && (m_due[0] == cyc);
      if (cap) void'(m_due.pop_front());
      pop  = (m_fifo.size() > 0) && rdy;
      room = (m_fifo.size() < DEPTH) || pop;
      if (pop) m_last = m_fifo.pop_front();
      if (clr) begin m_acc = 0; m_cnt = 0; m_ovf = 1'b0; end
      if (cap && room) begin
        m_fifo.push_back(fv);
        m_acc = (m_acc + int'(fv) > ACC_MAX) ? ACC_MAX : m_acc + int'(fv);
        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end else if (cap && !clr) begin
        m_ovf = 1'b1;
      end
      if (iss) m_due.push_back(cyc + LAT);
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 10'd0, 0, 0, 0);
    drive(1, 10'd5, 1, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    checks++; if (acc !== '0 || count !== 8'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_stats got acc=%0d count=%0d ovf=%0d exp=0/0/0", acc, count, overflow);
    end
    drive(0, 10'd0, 0, 0, 1);
    drive(0, 10'd0, 0, 0, 1);
    drive(0, 10'd0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_token_discard got=%0d exp=0", out_valid); end
  endtask

  task automatic test_single();
    drive(1, 10'($urandom_range(0, 1023)), 0, 0, 1);
    drive(0, 10'($urandom_range(0, 1023)), 0, 0, 1);
    drive(0, 10'($urandom_range(0, 1023)), 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0d exp=0", out_valid); end
    drive(0, 10'd75, 0, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_data !== 10'd75) begin
      failures++; $display("FAIL single_capture got valid=%0d data=%0d exp 1/75", out_valid, out_data);
    end
    checks++; if (acc !== 10'd75 || count !== 8'd1) begin
      failures++; $display("FAIL single_stats got acc=%0d count=%0d exp 75/1", acc, count);
    end
    drive(0, 10'd0, 1, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_data !== 10'd75) begin
      failures++; $display("FAIL single_pop got valid=%0d data=%0d exp 0/75", out_valid, out_data);
    end
  endtask

  task automatic test_fill_overflow();
    logic [N-1:0] vals [5];
    vals = '{10'd75, 10'd60, 10'd0, 10'd185, 10'd9};
    drive(0, 10'd0, 0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      drive(k < 5, (k >= 3) ? vals[k-3] : 10'd511, 0, 0, 1);
      if (k == 6) begin
        checks++; if (acc !== 10'd320 || count !== 8'd4 || overflow !== 1'b0 || out_valid !== 1'b1) begin
          failures++; $display("FAIL fill_full got acc=%0d count=%0d ovf=%0d valid=%0d exp 320/4/0/1", acc, count, overflow, out_valid);
        end
      end
    end
    checks++; if (overflow !== 1'b1 || acc !== 10'd320 || count !== 8'd4) begin
      failures++; $display("FAIL fill_drop got ovf=%0d acc=%0d count=%0d exp 1/320/4", overflow, acc, count);
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== vals[k]) begin
        failures++; $display("FAIL drain_order idx=%0d got valid=%0d data=%0d exp 1/%0d", k, out_valid, out_data, vals[k]);
      end
      drive(0, 10'd0, 1, 0, 1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int next_exp;
    bit rdy;
    next_exp = 1;
    drive(0, 10'd0, 0, 1, 1);
    for (int k = 0; k < 40; k++) begin
      rdy = (k >= LAT + 4);
      if (rdy && out_valid) begin
        checks++; if (out_data !== 10'(next_exp)) begin
          failures++; $display("FAIL b2b_seq got=%0d exp=%0d", out_data, next_exp);
        end
        next_exp++;
      end
      drive(k < 36, (k >= LAT) ? 10'(k - LAT + 1) : 10'd0, rdy, 0, 1);
      checks++; if (out_valid !== (m_fifo.size() > 0) || out_data !== exp_data()) begin
        failures++; $display("FAIL b2b_model got valid=%0d data=%0d exp %0d/%0d", out_valid, out_data, m_fifo.size() > 0, exp_data());
      end
    end
    checks++; if (overflow !== 1'b0 || count !== 8'd36) begin
      failures++; $display("FAIL b2b_stats got ovf=%0d count=%0d exp 0/36", overflow, count);
    end
  endtask

  task automatic test_saturation();
    drive(0, 10'd0, 1, 1, 1);
    for (int k = 0; k < 5; k++) drive(k < 2, (k == 3) ? 10'd1000 : (k == 4) ? 10'd100 : 10'd0, 1, 0, 1);
    checks++; if (acc !== 10'd1023 || count !== 8'd2) begin
      failures++; $display("FAIL acc_saturate got acc=%0d count=%0d exp 1023/2", acc, count);
    end
    for (int k = 0; k < 300 + LAT; k++) drive(k < 300, 10'($urandom_range(0, 1023)), 1, 0, 1);
    checks++; if (count !== 8'd255 || acc !== 10'd1023) begin
      failures++; $display("FAIL count_saturate got count=%0d acc=%0d exp 255/1023", count, acc);
    end
  endtask

  task automatic test_clear_capture();
    logic [N-1:0] vals [3];
    vals = '{10'd250, 10'd250, 10'd42};
    drive(0, 10'd0, 1, 0, 1);
    drive(0, 10'd0, 0, 1, 1);
    for (int k = 0; k < 6; k++) begin
      drive(k < 3, (k >= 3) ? vals[k-3] : 10'd0, 0, k == 5, 1);
      if (k == 4) begin
        checks++; if (acc !== 10'd500) begin failures++; $display("FAIL clear_pre_acc got=%0d exp=500", acc); end
      end
    end
    checks++; if (acc !== 10'd42 || count !== 8'd1 || overflow !== 1'b0) begin
      failures++; $display("FAIL clear_with_push got acc=%0d count=%0d ovf=%0d exp 42/1/0", acc, count, overflow);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== vals[k]) begin
        failures++; $display("FAIL clear_fifo_intact idx=%0d got valid=%0d data=%0d exp 1/%0d", k, out_valid, out_data, vals[k]);
      end
      drive(0, 10'd0, 1, 0, 1);
    end
  endtask

  task automatic test_reset_midflight();
    drive(0, 10'd0, 0, 1, 1);
    for (int k = 0; k < 5; k++) drive(k != 2, 10'($urandom_range(1, 1023)), 0, 0, 1);
    checks++; if (count !== 8'd2 || out_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_setup got count=%0d valid=%0d exp 2/1", count, out_valid);
    end
    drive(0, 10'd7, 0, 0, 0);
    for (int k = 0; k < LAT + 2; k++) begin
      drive(0, 10'($urandom_range(1, 1023)), 0, 0, 1);
      checks++; if (out_valid !== 1'b0 || out_data !== '0 || acc !== '0 || count !== 8'd0 || overflow !== 1'b0) begin
        failures++; $display("FAIL midrst_quiet k=%0d got valid=%0d data=%0d acc=%0d count=%0d ovf=%0d exp all 0",
                             k, out_valid, out_data, acc, count, overflow);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      drive($urandom_range(0, 99) < 60, 10'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3, $urandom_range(0, 199) != 0);
      checks++; if (out_valid !== (m_fifo.size() > 0) || out_data !== exp_data()) begin
        failures++; $display("FAIL rand_fifo k=%0d got valid=%0d data=%0d exp %0d/%0d", k, out_valid, out_data, m_fifo.size() > 0, exp_data());
      end
      checks++; if (acc !== 10'(m_acc) || count !== 8'(m_cnt) || overflow !== m_ovf) begin
        failures++; $display("FAIL rand_stats k=%0d got acc=%0d count=%0d ovf=%0d exp %0d/%0d/%0d", k, acc, count, overflow, m_acc, m_cnt, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_saturation();
    test_clear_capture();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_result_collector.md
Name: pipe_result_collector

Overview:
Downstream consumer of the 3-stage arithmetic pipeline's result bus f.
- Tracks which cycles carry real results using an issue-aligned valid delay line.
- Captures valid results into a small first-word-fall-through FIFO with a ready/valid output.
- Keeps running statistics: saturating sum, sample count and sticky overflow flag.

Parameters:
- N, 10, result data width (matches upstream pipeline width).
- LAT, 3, edges from operand issue to the result capture edge (>=1).
- DEPTH, 4, FIFO entries (power of two, >=2).
- ACC_W, 16, accumulator width (>=N).

Ports:
- clk  in  1  rising-edge clock, shared with upstream pipeline.
- rst_n  in  1  synchronous active-low reset.
- issue  in  1  high when the upstream pipeline samples a real operand set at this edge.
- f  in  N  upstream result bus; must be stable at each capture edge.
- clear  in  1  synchronous clear of statistics only.
- out_data  out  N  FIFO head entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data at this edge.
- acc  out  ACC_W  saturating sum of accepted results.
- count  out  8  saturating count of accepted results.
- overflow  out  1  sticky: at least one valid result dropped because the FIFO was full.

Behaviour:
- Reset: rst_n low at an edge clears everything; takes priority over all other inputs, including mid-operation.
  - Delay line all 0, FIFO empty, out_valid=0, out_data=0, acc=0, count=0, overflow=0.
  - In-flight issue tokens are discarded; no results from before reset are ever captured.
- Delay line: LAT-bit shift register fed by issue. cap_v (the tap) is high in the cycle before edge t+LAT when issue was sampled high at edge t.
- Capture: at an edge with cap_v=1, f is pushed if the FIFO has room at that edge.
  - Room exists if count_fifo<DEPTH, or if FIFO is full and a pop occurs at the same edge (push and pop together).
  - No room: result dropped, overflow<=1, acc and count unchanged.
- FIFO: first-word fall-through, registered.
  - out_valid=1 iff occupancy>0.
  - out_data is the oldest entry; holds value while out_valid=1 and out_ready=0.
  - Pop at an edge with out_valid&&out_ready.
  - out_ready while empty: no effect.
  - Push into an empty FIFO: out_valid=1 and out_data=f immediately after that edge.
  - Simultaneous push and pop on a non-empty FIFO: occupancy unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - When empty, out_data holds the last popped value; 0 after reset.
- Latency: issue at edge t → data visible at out_data after edge t+LAT. Back-to-back issue gives one capture per edge.
- Statistics, updated only on accepted pushes:
  - acc <= min(acc + zero-extended f, 2^ACC_W-1).
  - count <= min(count+1, 255).
- clear: sets acc=0, count=0, overflow=0; does not touch the FIFO or delay line.
  - clear together with an accepted push: acc=f, count=1.
  - clear together with a dropped push: overflow=0; clear wins.
- No combinational path from f or issue to any output; out_valid depends only on registered state.

Test Plan:
- Reset then single issue at edge t, with f=75 held at edge t+3 → out_valid rises after edge t+3, out_data=75, acc=75, count=1.
  - Pop with out_ready=1 → out_valid=0 next cycle.
- Issue on 4 consecutive edges with f=75,60,0,185 and out_ready=0 → FIFO full, acc=320, count=4, overflow=0.
  - A 5th issue with f=9 → overflow=1, acc stays 320.
  - Draining yields 75,60,0,185 in order.
- FIFO full with out_ready=1 held and continuous issues with f=1,2,3,... → every result accepted, no overflow, output sequence contiguous.
- Accumulator saturation: ACC_W=10, captures f=1000 then f=100 → acc=1023.
  - Force 300 captures → count=255.
- clear asserted on the same edge as a capture with f=42 after acc=500 → acc=42, count=1, overflow=0, FIFO contents intact.
- rst_n low for one edge while two issue tokens are in flight and the FIFO holds 2 entries → no later captures, out_valid=0, all statistics 0.
